// File: rtl/branch_predictor_pkg.sv
// Package for the branch predictor: opcode constants, counter reset value,
// state type and immediate-decode helpers (all values sourced from Defines.v).
package branch_predictor_pkg;

`include "Defines.v"

    localparam logic [6:0] OPC_JAL    = `BP_OPC_JAL;
    localparam logic [6:0] OPC_BRANCH = `BP_OPC_BRANCH;
    localparam logic [6:0] OPC_JALR   = `BP_OPC_JALR;
    localparam logic [1:0] CNT_RESET  = `BP_CNT_RESET;

    typedef enum logic {
        ST_INIT = `BP_STATE_INIT,
        ST_RUN  = `BP_STATE_RUN
    } bp_state_t;

    // Sign-extended J-type immediate, bit 0 forced to zero.
    function automatic logic [31:0] imm_j(input logic [31:0] i);
        return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    endfunction

    // Sign-extended B-type immediate, bit 0 forced to zero.
    function automatic logic [31:0] imm_b(input logic [31:0] i);
        return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/Defines.v
// Shared constants for the branch predictor: RV32 control-flow opcodes,
// the BHT counter initialisation value and the INIT/RUN state encodings.
`ifndef BP_DEFINES_V
`define BP_DEFINES_V

`define BP_OPC_JAL     7'b1101111
`define BP_OPC_BRANCH  7'b1100011
`define BP_OPC_JALR    7'b1100111

`define BP_CNT_RESET   2'b01

`define BP_STATE_INIT  1'b0
`define BP_STATE_RUN   1'b1

`endif

// File: rtl/bp_sat_counter.sv
// 2-bit saturating counter next-state logic.
// Ports: cnt (current value), taken (resolved outcome), cnt_next (updated value).
module bp_sat_counter (
    input  logic [1:0] cnt,
    input  logic       taken,
    output logic [1:0] cnt_next
);

    always_comb begin
        cnt_next = cnt;
        if (taken) begin
            if (cnt != 2'b11) cnt_next = cnt + 2'd1;
        end else begin
            if (cnt != 2'b00) cnt_next = cnt - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Next-PC predictor: static JAL targets, a 2-bit counter BHT for conditional
// branches and a direct-mapped BTB for JALR. Lookups are combinational; tables
// are initialised by a one-entry-per-cycle INIT sweep after reset.
// Optional: define BRANCH_PREDICTOR_GSHARE_EN to XOR a global history register
// into the BHT index.
// Ports: clk, rst (sync active-high); instr/pc lookup in, predicted_pc/
// predicted_taken out; ready (tables initialised); upd_* resolved-update bus.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int unsigned BHT_ENTRIES = 64,
    parameter int unsigned BTB_ENTRIES = 16,
    parameter int unsigned TAG_W       = 8,
    parameter int unsigned HIST_W      = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    output logic [31:0] predicted_pc,
    output logic        predicted_taken,
    output logic        ready,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_is_branch,
    input  logic        upd_is_jalr,
    input  logic        upd_taken,
    input  logic [31:0] upd_target
);

    localparam int unsigned BHT_IW = $clog2(BHT_ENTRIES);
    localparam int unsigned BTB_IW = $clog2(BTB_ENTRIES);
    localparam int unsigned INIT_N = (BHT_ENTRIES > BTB_ENTRIES) ? BHT_ENTRIES : BTB_ENTRIES;
    localparam int unsigned CNT_W  = $clog2(INIT_N);
    localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_N - 1);

    bp_state_t          state;
    logic [CNT_W-1:0]   init_idx;

    logic [1:0]         bht        [BHT_ENTRIES];
    logic               btb_valid  [BTB_ENTRIES];
    logic [TAG_W-1:0]   btb_tag    [BTB_ENTRIES];
    logic [31:0]        btb_target [BTB_ENTRIES];

    logic [BHT_IW-1:0]  look_idx;
    logic [BHT_IW-1:0]  upd_idx;
    logic [BTB_IW-1:0]  look_bi;
    logic [BTB_IW-1:0]  upd_bi;
    logic [TAG_W-1:0]   look_tag;
    logic [TAG_W-1:0]   upd_tag;
    logic [1:0]         cnt_next;
    logic               upd_br_acc;
    logic               upd_jalr_acc;
    logic               unused_upd_pc;

    assign unused_upd_pc = ^upd_pc;

`ifdef BRANCH_PREDICTOR_GSHARE_EN
    logic [HIST_W-1:0]  ghr;
    assign look_idx = pc[BHT_IW+1:2] ^ BHT_IW'(ghr);
    assign upd_idx  = upd_pc[BHT_IW+1:2] ^ BHT_IW'(ghr);
`else
    assign look_idx = pc[BHT_IW+1:2];
    assign upd_idx  = upd_pc[BHT_IW+1:2];
`endif

    assign look_bi  = pc[BTB_IW+1:2];
    assign upd_bi   = upd_pc[BTB_IW+1:2];
    assign look_tag = pc[TAG_W+BTB_IW+1:BTB_IW+2];
    assign upd_tag  = upd_pc[TAG_W+BTB_IW+1:BTB_IW+2];

    // A dual-flagged update counts as a branch only.
    assign upd_br_acc   = ready && upd_valid && upd_is_branch;
    assign upd_jalr_acc = ready && upd_valid && upd_is_jalr && !upd_is_branch;

    bp_sat_counter u_sat (
        .cnt      (bht[upd_idx]),
        .taken    (upd_taken),
        .cnt_next (cnt_next)
    );

    // Init sweep / run state machine with registered ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_INIT;
            init_idx <= '0;
            ready    <= 1'b0;
`ifdef BRANCH_PREDICTOR_GSHARE_EN
            ghr      <= '0;
`endif
        end else begin
            case (state)
                ST_INIT: begin
                    if (init_idx == INIT_LAST) begin
                        state <= ST_RUN;
                        ready <= 1'b1;
                    end else begin
                        init_idx <= init_idx + CNT_W'(1);
                    end
                end
                ST_RUN: begin
`ifdef BRANCH_PREDICTOR_GSHARE_EN
                    if (upd_br_acc) ghr <= HIST_W'({ghr, upd_taken});
`endif
                end
                default: state <= ST_INIT;
            endcase
        end
    end

    // Table writes: sweep during INIT, resolved updates once ready.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == ST_INIT) begin
                if (32'(init_idx) < BHT_ENTRIES) bht[BHT_IW'(init_idx)] <= CNT_RESET;
                if (32'(init_idx) < BTB_ENTRIES) btb_valid[BTB_IW'(init_idx)] <= 1'b0;
            end else begin
                if (upd_br_acc) bht[upd_idx] <= cnt_next;
                if (upd_jalr_acc) begin
                    btb_valid[upd_bi]  <= 1'b1;
                    btb_tag[upd_bi]    <= upd_tag;
                    btb_target[upd_bi] <= upd_target;
                end
            end
        end
    end

    // Zero-latency lookup; reads pre-update table contents.
    always_comb begin
        predicted_pc    = pc + 32'd4;
        predicted_taken = 1'b0;
        case (instr[6:0])
            OPC_JAL: begin
                predicted_pc    = pc + imm_j(instr);
                predicted_taken = 1'b1;
            end
            OPC_BRANCH: begin
                if (ready ? bht[look_idx][1] : imm_b(instr)[31]) begin
                    predicted_pc    = pc + imm_b(instr);
                    predicted_taken = 1'b1;
                end
            end
            OPC_JALR: begin
                if (ready && btb_valid[look_bi] && (btb_tag[look_bi] == look_tag)) begin
                    predicted_pc    = btb_target[look_bi];
                    predicted_taken = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] predicted_pc;
    logic        predicted_taken;
    logic        ready;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_is_branch;
    logic        upd_is_jalr;
    logic        upd_taken;
    logic [31:0] upd_target;

    always #5 clk = ~clk;

    branch_predictor dut (
        .clk             (clk),
        .rst             (rst),
        .instr           (instr),
        .pc              (pc),
        .predicted_pc    (predicted_pc),
        .predicted_taken (predicted_taken),
        .ready           (ready),
        .upd_valid       (upd_valid),
        .upd_pc          (upd_pc),
        .upd_is_branch   (upd_is_branch),
        .upd_is_jalr     (upd_is_jalr),
        .upd_taken       (upd_taken),
        .upd_target      (upd_target)
    );

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic        taken;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_err = 0;

    localparam logic [31:0] JALR_I = {12'd0, 5'd1, 3'd0, 5'd1, 7'b1100111};
    localparam logic [31:0] ADDI_I = 32'h0000_0013;

    function automatic logic [31:0] enc_b(input int imm);
        logic [12:0] b;
        b = 13'(imm);
        return {b[12], b[10:5], 5'd2, 5'd1, 3'd0, b[4:1], b[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input int imm);
        logic [20:0] j;
        j = 21'(imm);
        return {j[20], j[10:1], j[11], j[19:12], 5'd1, 7'b1101111};
    endfunction

    task automatic push_exp(input string n, input logic [31:0] p, input logic t);
        exp_t x;
        x.name = n; x.pc = p; x.taken = t;
        sb.push_back(x);
    endtask

    task automatic lookup(input logic [31:0] i, input logic [31:0] p);
        @(negedge clk);
        instr = i;
        pc    = p;
        #1;
    endtask

    task automatic update(input logic [31:0] p, input logic br, input logic jr,
                          input logic t, input logic [31:0] tgt);
        @(negedge clk);
        upd_valid = 1'b1; upd_pc = p; upd_is_branch = br; upd_is_jalr = jr;
        upd_taken = t; upd_target = tgt;
        @(posedge clk);
        #1 upd_valid = 1'b0;
    endtask

    task automatic test_reset();
        int cycles;
        rst = 1'b1; upd_valid = 1'b0; upd_pc = '0; upd_is_branch = 1'b0;
        upd_is_jalr = 1'b0; upd_taken = 1'b0; upd_target = '0;
        instr = ADDI_I; pc = '0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (ready !== 1'b0) begin
            n_err++; $display("FAIL reset_ready: got %b expected 0", ready);
        end
        push_exp("rst_addi", 32'h0000_0104, 1'b0);
        push_exp("rst_fwd_branch", 32'h0000_0104, 1'b0);
        push_exp("rst_back_branch", 32'h0000_00E0, 1'b1);
        push_exp("rst_jal", 32'h0000_0FF8, 1'b1);
        push_exp("rst_jalr", 32'h0000_0304, 1'b0);
        for (int k = 0; k < 5; k++) begin
            case (k)
                0: lookup(ADDI_I, 32'h100);
                1: lookup(enc_b(16), 32'h100);
                2: lookup(enc_b(-32), 32'h100);
                3: lookup(enc_j(-8), 32'h1000);
                default: lookup(JALR_I, 32'h300);
            endcase
            e = sb.pop_front();
            n_cmp++;
            if (predicted_pc !== e.pc || predicted_taken !== e.taken) begin
                n_err++;
                $display("FAIL %s: got pc=%h taken=%b expected pc=%h taken=%b",
                         e.name, predicted_pc, predicted_taken, e.pc, e.taken);
            end
        end
        lookup(enc_b(16), 32'h100);
        rst = 1'b0;
        cycles = 0;
        while (cycles < 200) begin
            @(posedge clk); #1;
            cycles++;
            if (ready === 1'b1) break;
        end
        n_cmp++;
        if (cycles !== 64) begin
            n_err++; $display("FAIL ready_latency: got %0d cycles expected 64", cycles);
        end
        push_exp("run_fwd_branch", 32'h0000_0104, 1'b0);
        lookup(enc_b(16), 32'h100);
        e = sb.pop_front();
        n_cmp++;
        if (predicted_pc !== e.pc || predicted_taken !== e.taken) begin
            n_err++;
            $display("FAIL %s: got pc=%h taken=%b expected pc=%h taken=%b",
                     e.name, predicted_pc, predicted_taken, e.pc, e.taken);
        end
    endtask

    task automatic test_jal();
        push_exp("jal_neg", 32'h0000_1FF8, 1'b1);
        push_exp("jal_pos_far", 32'h0001_2000, 1'b1);
        push_exp("run_back_branch_01", 32'h0000_0124, 1'b0);
        for (int k = 0; k < 3; k++) begin
            case (k)
                0: lookup(enc_j(-8), 32'h2000);
                1: lookup(enc_j(32'h10000), 32'h2000);
                default: lookup(enc_b(-64), 32'h120);
            endcase
            e = sb.pop_front();
            n_cmp++;
            if (predicted_pc !== e.pc || predicted_taken !== e.taken) begin
                n_err++;
                $display("FAIL %s: got pc=%h taken=%b expected pc=%h taken=%b",
                         e.name, predicted_pc, predicted_taken, e.pc, e.taken);
            end
        end
    endtask

    task automatic test_counter();
        repeat (3) update(32'h200, 1'b1, 1'b0, 1'b1, '0);
        push_exp("bht_taken", 32'h0000_0240, 1'b1);
        lookup(enc_b(32'h40), 32'h200);
        e = sb.pop_front();
        n_cmp++;
        if (predicted_pc !== e.pc || predicted_taken !== e.taken) begin
            n_err++;
            $display("FAIL %s: got pc=%h taken=%b expected pc=%h taken=%b",
                     e.name, predicted_pc, predicted_taken, e.pc, e.taken);
        end
        repeat (2) update(32'h200, 1'b1, 1'b0, 1'b0, '0);
        push_exp("bht_not_taken", 32'h0000_0204, 1'b0);
        lookup(enc_b(32'h40), 32'h200);
        e = sb.pop_front();
        n_cmp++;
        if (predicted_pc !== e.pc || predicted_taken !== e.taken) begin
            n_err++;
            $display("FAIL %s: got pc=%h taken=%b expected pc=%h taken=%b",
                     e.name, predicted_pc, predicted_taken, e.pc, e.taken);
        end
    endtask

    task automatic test_saturation();
        repeat (5) update(32'h208, 1'b1, 1'b0, 1'b1, '0);
        update(32'h208, 1'b1, 1'b0, 1'b0, '0);
        push_exp("sat_11_to_10", 32'h0000_0218, 1'b1);
        lookup(enc_b(16), 32'h208);
        e = sb.pop_front();
        n_cmp++;
        if (predicted_pc !== e.pc || predicted_taken !== e.taken) begin
            n_err++;
            $display("FAIL %s: got pc=%h taken=%b expected pc=%h taken=%b",
                     e.name, predicted_pc, predicted_taken, e.pc, e.taken);
        end
        repeat (4) update(32'h20C, 1'b1, 1'b0, 1'b0, '0);
        update(32'h20C, 1'b1, 1'b0, 1'b1, '0);
        push_exp("sat_00_to_01", 32'h0000_0210, 1'b0);
        lookup(enc_b(16), 32'h20C);
        e = sb.pop_front();
        n_cmp++;
        if (predicted_pc !== e.pc || predicted_taken !== e.taken) begin
            n_err++;
            $display("FAIL %s: got pc=%h taken=%b expected pc=%h taken=%b",
                     e.name, predicted_pc, predicted_taken, e.pc, e.taken);
        end
    endtask

    task automatic test_btb();
        update(32'h300, 1'b0, 1'b1, 1'b1, 32'h8000);
        update(32'h50C, 1'b1, 1'b1, 1'b1, 32'h7777);
        push_exp("btb_hit", 32'h0000_8000, 1'b1);
        push_exp("btb_tag_miss", 32'h0000_0344, 1'b0);
        push_exp("dual_no_btb", 32'h0000_0510, 1'b0);
        push_exp("dual_as_branch", 32'h0000_052C, 1'b1);
        for (int k = 0; k < 4; k++) begin
            case (k)
                0: lookup(JALR_I, 32'h300);
                1: lookup(JALR_I, 32'h340);
                2: lookup(JALR_I, 32'h50C);
                default: lookup(enc_b(32'h20), 32'h50C);
            endcase
            e = sb.pop_front();
            n_cmp++;
            if (predicted_pc !== e.pc || predicted_taken !== e.taken) begin
                n_err++;
                $display("FAIL %s: got pc=%h taken=%b expected pc=%h taken=%b",
                         e.name, predicted_pc, predicted_taken, e.pc, e.taken);
            end
        end
        update(32'h300, 1'b0, 1'b1, 1'b1, 32'h9000);
        push_exp("btb_overwrite", 32'h0000_9000, 1'b1);
        lookup(JALR_I, 32'h300);
        e = sb.pop_front();
        n_cmp++;
        if (predicted_pc !== e.pc || predicted_taken !== e.taken) begin
            n_err++;
            $display("FAIL %s: got pc=%h taken=%b expected pc=%h taken=%b",
                     e.name, predicted_pc, predicted_taken, e.pc, e.taken);
        end
    endtask

    task automatic test_same_cycle();
        @(negedge clk);
        instr = enc_b(32'h20); pc = 32'h210;
        upd_valid = 1'b1; upd_pc = 32'h210; upd_is_branch = 1'b1;
        upd_is_jalr = 1'b0; upd_taken = 1'b1; upd_target = '0;
        push_exp("same_cycle_pre", 32'h0000_0214, 1'b0);
        push_exp("same_cycle_post", 32'h0000_0230, 1'b1);
        #1;
        e = sb.pop_front();
        n_cmp++;
        if (predicted_pc !== e.pc || predicted_taken !== e.taken) begin
            n_err++;
            $display("FAIL %s: got pc=%h taken=%b expected pc=%h taken=%b",
                     e.name, predicted_pc, predicted_taken, e.pc, e.taken);
        end
        @(posedge clk);
        #1 upd_valid = 1'b0;
        lookup(enc_b(32'h20), 32'h210);
        e = sb.pop_front();
        n_cmp++;
        if (predicted_pc !== e.pc || predicted_taken !== e.taken) begin
            n_err++;
            $display("FAIL %s: got pc=%h taken=%b expected pc=%h taken=%b",
                     e.name, predicted_pc, predicted_taken, e.pc, e.taken);
        end
    endtask

    task automatic test_rst_in_run();
        int cycles;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (ready !== 1'b0) begin
            n_err++; $display("FAIL rerst_ready_drop: got %b expected 0", ready);
        end
        @(negedge clk);
        rst = 1'b0;
        update(32'h3C0, 1'b0, 1'b1, 1'b1, 32'h1234);
        update(32'h218, 1'b1, 1'b0, 1'b1, '0);
        cycles = 0;
        while (cycles < 200) begin
            @(posedge clk); #1;
            cycles++;
            if (ready === 1'b1) break;
        end
        n_cmp++;
        if (ready !== 1'b1) begin
            n_err++; $display("FAIL rerst_ready_timeout: got %b expected 1", ready);
        end
        push_exp("rerst_btb_300", 32'h0000_0304, 1'b0);
        push_exp("rerst_btb_50c", 32'h0000_0510, 1'b0);
        push_exp("rerst_dropped_jalr", 32'h0000_03C4, 1'b0);
        push_exp("rerst_bht_208", 32'h0000_020C, 1'b0);
        push_exp("rerst_dropped_branch", 32'h0000_021C, 1'b0);
        for (int k = 0; k < 5; k++) begin
            case (k)
                0: lookup(JALR_I, 32'h300);
                1: lookup(JALR_I, 32'h50C);
                2: lookup(JALR_I, 32'h3C0);
                3: lookup(enc_b(16), 32'h208);
                default: lookup(enc_b(16), 32'h218);
            endcase
            e = sb.pop_front();
            n_cmp++;
            if (predicted_pc !== e.pc || predicted_taken !== e.taken) begin
                n_err++;
                $display("FAIL %s: got pc=%h taken=%b expected pc=%h taken=%b",
                         e.name, predicted_pc, predicted_taken, e.pc, e.taken);
            end
        end
    endtask

    initial begin
        test_reset();
        test_jal();
        test_counter();
        test_saturation();
        test_btb();
        test_same_cycle();
        test_rst_in_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
